chimp_game_engine: RTL and testbench
====================================

Name: chimp_game_engine

Overview:
- Parametrised successor to the fixed 8x8 chimp-test datapath and control path.
- Owns the board store, random tile placement, the click-sequence check, level and strike tracking, and the hide/show mode.
- Sits between the PRNG, the mouse/keyboard front ends (click coordinates, start key) and the VGA renderer, which reads cells through a registered read port instead of a full-board bus.

Parameters:
- GRID_W, 8, columns (power of two, 2..16)
- GRID_H, 8, rows (power of two, 2..16); log2(GRID_W)+log2(GRID_H) <= 8
- START_COUNT, 4, tiles on level 1
- MAX_COUNT, 32, tiles on final level; <= GRID_W*GRID_H
- MAX_STRIKES, 3, wrong clicks allowed before game over
- SHOW_CYCLES, 0, 0 = numbers hide on first correct click; N>0 = numbers also auto-hide N cycles after placement
- Derived: XW=clog2(GRID_W), YW=clog2(GRID_H), NUM_W=clog2(MAX_COUNT+1), LVL_W=clog2(MAX_COUNT-START_COUNT+2)

Ports:
- clk  in  1  system clock
- iReset  in  1  asynchronous, active-high reset
- iStart  in  1  single-cycle pulse (space key); starts or continues the game
- iClick  in  1  single-cycle pulse, mouse pressed
- iClickX  in  XW  clicked box column
- iClickY  in  YW  clicked box row
- iClickValid  in  1  high if click coordinates lie inside the grid
- iRand  in  8  PRNG output, new value every cycle
- iRdX  in  XW  renderer read column
- iRdY  in  YW  renderer read row
- oRdActive  out  1  cell holds an uncleared tile (1-cycle latency)
- oRdShown  out  1  tile number visible (1-cycle latency)
- oRdNum  out  NUM_W  tile number 1..count, 0 if empty (1-cycle latency)
- oLevel  out  LVL_W  current level, starting at 1
- oStrikes  out  2+  strikes used so far
- oExpected  out  NUM_W  next number the player must click
- oState  out  3  state encoding, from the package
- oLevelWin  out  1  1-cycle pulse on level cleared
- oLevelFail  out  1  1-cycle pulse on wrong click

Behaviour:
- Reset (async):
  - State = IDLE, level = 1, strikes = 0, expected = 1, hidden = 0.
  - All cells cleared; read outputs 0; pulses 0.
  - Reset mid-operation abandons everything; no partial state survives.
- count = min(START_COUNT + level - 1, MAX_COUNT).
- IDLE: iStart -> CLEAR.
- CLEAR:
  - Walks one cell per cycle, taking exactly GRID_W*GRID_H cycles.
  - Sets expected = 1, hidden = 0, placed = 0, then -> PLACE.
- PLACE:
  - Each cycle, candidate x = iRand[XW-1:0] and y = iRand[XW+YW-1:XW].
  - If the candidate cell is empty, write num = placed+1 and increment placed; otherwise retry next cycle.
  - When placed == count -> PLAY, and load the show timer with SHOW_CYCLES.
- PLAY:
  - Clicks are evaluated on the iClick cycle.
  - A click is ignored if iClickValid = 0 or the cell is inactive.
  - Correct click (num == expected): clear the cell, increment expected, set hidden = 1.
    - If the cleared num == count, -> WIN and pulse oLevelWin.
  - Wrong click: increment strikes and pulse oLevelFail.
    - If strikes reaches MAX_STRIKES -> OVER, otherwise -> FAIL.
  - If SHOW_CYCLES > 0 and the timer expires, set hidden = 1.
  - A click and timer expiry in the same cycle is processed as a click.
- WIN:
  - iStart -> CLEAR with level+1.
  - If count was already MAX_COUNT -> DONE instead.
- FAIL: iStart -> CLEAR at the same level (tiles re-placed).
- OVER / DONE: iStart resets level, strikes and expected and goes to CLEAR.
- iStart in CLEAR, PLACE or PLAY is ignored. iClick outside PLAY is ignored.
- Read port:
  - Registered, 1-cycle latency, valid in every state.
  - oRdShown = active & ~hidden.
  - During CLEAR/PLACE the port returns in-progress contents.
- Board and level counters never wrap: level saturates at its final value, strikes stop at MAX_STRIKES.

Decomposition:
- chimp_pkg holds:
  - the state enum (IDLE, CLEAR, PLACE, PLAY, WIN, FAIL, OVER, DONE);
  - the cell struct {active, num};
  - the shared width helper functions.
- One sub-module, chimp_cell_placer: owns the CLEAR walk and the PLACE retry loop, with a done handshake back to the engine FSM.

Test Plan:
1. Reset, then iStart with forced iRand sequence covering cells 0..3 -> after 64+4 cycles state = PLAY, cells 0..3 hold nums 1..4, all shown.
2. Forced iRand repeating an occupied cell 5 times -> PLACE stalls 5 extra cycles, no tile is overwritten, and placed ends at 4.
3. Click nums 1,2,3,4 in order -> oRdShown = 0 after the first click, oLevelWin pulses once, iStart then places 5 tiles at level 2.
4. Click num 2 first -> oLevelFail pulses, strikes = 1, state = FAIL. Repeated until strikes = 3 -> state = OVER.
5. SHOW_CYCLES = 10, no click -> hidden asserts exactly 10 cycles after PLAY entry. Click plus expiry on the same cycle -> the click is processed.
6. Assert iReset mid-PLACE -> all outputs zero immediately, state = IDLE, level = 1.

Source files
------------

// File: rtl/chimp_pkg.sv
// Shared types and width helpers for the chimp-test game engine.
package chimp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    PLACE = 3'd2,
    PLAY  = 3'd3,
    WIN   = 3'd4,
    FAIL  = 3'd5,
    OVER  = 3'd6,
    DONE  = 3'd7
  } state_t;

  // Wide enough for any legal MAX_COUNT (up to 256 tiles).
  localparam int unsigned CELL_NUM_W = 9;

  typedef struct packed {
    logic                  active;
    logic [CELL_NUM_W-1:0] num;
  } cell_t;

  function automatic int unsigned w_min(input int unsigned v, input int unsigned lo);
    return (v < lo) ? lo : v;
  endfunction

  function automatic int unsigned num_w(input int unsigned max_count);
    return w_min($clog2(max_count + 1), 1);
  endfunction

  function automatic int unsigned lvl_w(input int unsigned start_count, input int unsigned max_count);
    return w_min($clog2(max_count - start_count + 2), 1);
  endfunction

  function automatic int unsigned strike_w(input int unsigned max_strikes);
    return w_min($clog2(max_strikes + 1), 2);
  endfunction

endpackage

// File: rtl/chimp_cell_placer.sv
// Clears the board one cell per cycle, then drops numbered tiles on random empty cells.
module chimp_cell_placer
  import chimp_pkg::*;
#(
  parameter int unsigned CELLS = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned NUM_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] count,
  input  logic [7:0]       rand_val,
  input  logic             cand_busy,
  output logic [AW-1:0]    cand_addr_c,
  output logic             wr_en_c,
  output logic [AW-1:0]    wr_addr_c,
  output logic             wr_active_c,
  output logic [NUM_W-1:0] wr_num_c,
  output logic             clear_done_c,
  output logic             place_done_c
);

  typedef enum logic [1:0] {P_IDLE, P_CLEAR, P_PLACE} pstate_t;

  pstate_t          pstate;
  logic [AW-1:0]    idx;
  logic [NUM_W-1:0] placed;
  logic             unused_rand_c;

  // Candidate {y, x} comes straight from the low PRNG bits.
  assign cand_addr_c   = rand_val[AW-1:0];
  assign unused_rand_c = ^rand_val;

  always_comb begin
    wr_en_c      = 1'b0;
    wr_addr_c    = idx;
    wr_active_c  = 1'b0;
    wr_num_c     = '0;
    clear_done_c = 1'b0;
    place_done_c = 1'b0;
    case (pstate)
      P_CLEAR: begin
        wr_en_c      = 1'b1;
        clear_done_c = (idx == AW'(CELLS - 1));
      end
      P_PLACE: begin
        if (!cand_busy) begin
          wr_en_c      = 1'b1;
          wr_addr_c    = cand_addr_c;
          wr_active_c  = 1'b1;
          wr_num_c     = placed + NUM_W'(1);
          place_done_c = (placed + NUM_W'(1) == count);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate <= P_IDLE;
      idx    <= '0;
      placed <= '0;
    end else begin
      case (pstate)
        P_IDLE: begin
          if (start) begin
            pstate <= P_CLEAR;
            idx    <= '0;
          end
        end
        P_CLEAR: begin
          idx <= idx + AW'(1);
          if (clear_done_c) begin
            pstate <= P_PLACE;
            placed <= '0;
          end
        end
        P_PLACE: begin
          if (wr_en_c) begin
            placed <= placed + NUM_W'(1);
            if (place_done_c) pstate <= P_IDLE;
          end
        end
        default: pstate <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/chimp_game_engine.sv
// Chimp-test game engine: board store, click checking, level/strike tracking, renderer read port.
module chimp_game_engine
  import chimp_pkg::*;
#(
  parameter int unsigned GRID_W      = 8,
  parameter int unsigned GRID_H      = 8,
  parameter int unsigned START_COUNT = 4,
  parameter int unsigned MAX_COUNT   = 32,
  parameter int unsigned MAX_STRIKES = 3,
  parameter int unsigned SHOW_CYCLES = 0
) (
  input  logic                                     clk,
  input  logic                                     iReset,
  input  logic                                     iStart,
  input  logic                                     iClick,
  input  logic [$clog2(GRID_W)-1:0]                iClickX,
  input  logic [$clog2(GRID_H)-1:0]                iClickY,
  input  logic                                     iClickValid,
  input  logic [7:0]                               iRand,
  input  logic [$clog2(GRID_W)-1:0]                iRdX,
  input  logic [$clog2(GRID_H)-1:0]                iRdY,
  output logic                                     oRdActive,
  output logic                                     oRdShown,
  output logic [num_w(MAX_COUNT)-1:0]              oRdNum,
  output logic [lvl_w(START_COUNT, MAX_COUNT)-1:0] oLevel,
  output logic [strike_w(MAX_STRIKES)-1:0]         oStrikes,
  output logic [num_w(MAX_COUNT)-1:0]              oExpected,
  output logic [2:0]                               oState,
  output logic                                     oLevelWin,
  output logic                                     oLevelFail
);

  localparam int unsigned XW      = $clog2(GRID_W);
  localparam int unsigned YW      = $clog2(GRID_H);
  localparam int unsigned AW      = XW + YW;
  localparam int unsigned CELLS   = GRID_W * GRID_H;
  localparam int unsigned NUM_W   = num_w(MAX_COUNT);
  localparam int unsigned LVL_W   = lvl_w(START_COUNT, MAX_COUNT);
  localparam int unsigned SW      = strike_w(MAX_STRIKES);
  localparam int unsigned TW      = w_min($clog2(SHOW_CYCLES + 1), 1);
  localparam int unsigned CW      = NUM_W + 1;
  localparam int unsigned LVL_MAX = MAX_COUNT - START_COUNT + 1;

  state_t           state;
  logic             hidden;
  logic [TW-1:0]    timer;
  cell_t            board [CELLS];

  logic [CW-1:0]    count_sum_c;
  logic [NUM_W-1:0] count_c;
  logic             is_final_c;
  logic             go_c;
  logic [AW-1:0]    click_addr_c;
  cell_t            click_cell_c;
  cell_t            rd_cell_c;
  logic             click_hit_c;
  logic             click_ok_c;
  logic             unused_num_c;

  logic [AW-1:0]    cand_addr_c;
  logic             cand_busy_c;
  logic             pl_we_c;
  logic [AW-1:0]    pl_addr_c;
  logic             pl_active_c;
  logic [NUM_W-1:0] pl_num_c;
  cell_t            pl_cell_c;
  logic             clear_done_c;
  logic             place_done_c;

  assign oState = state;

  // Tiles on this level, clamped at the final level's count.
  always_comb begin
    count_sum_c = CW'(START_COUNT) + CW'(oLevel) - CW'(1);
    count_c     = (count_sum_c > CW'(MAX_COUNT)) ? NUM_W'(MAX_COUNT) : NUM_W'(count_sum_c);
    is_final_c  = (count_c == NUM_W'(MAX_COUNT));
  end

  always_comb begin
    go_c = 1'b0;
    if (iStart) begin
      case (state)
        IDLE, FAIL, OVER, DONE: go_c = 1'b1;
        WIN:                    go_c = !is_final_c;
        default:                go_c = 1'b0;
      endcase
    end
  end

  always_comb begin
    click_addr_c = {iClickY, iClickX};
    click_cell_c = board[click_addr_c];
    rd_cell_c    = board[{iRdY, iRdX}];
    click_hit_c  = (state == PLAY) && iClick && iClickValid && click_cell_c.active;
    click_ok_c   = click_hit_c && (click_cell_c.num == CELL_NUM_W'(oExpected));
    cand_busy_c  = board[cand_addr_c].active;
    pl_cell_c    = '{active: pl_active_c, num: CELL_NUM_W'(pl_num_c)};
  end

  assign unused_num_c = ^rd_cell_c.num;

  chimp_cell_placer #(
    .CELLS (CELLS),
    .AW    (AW),
    .NUM_W (NUM_W)
  ) u_placer (
    .clk          (clk),
    .rst          (iReset),
    .start        (go_c),
    .count        (count_c),
    .rand_val     (iRand),
    .cand_busy    (cand_busy_c),
    .cand_addr_c  (cand_addr_c),
    .wr_en_c      (pl_we_c),
    .wr_addr_c    (pl_addr_c),
    .wr_active_c  (pl_active_c),
    .wr_num_c     (pl_num_c),
    .clear_done_c (clear_done_c),
    .place_done_c (place_done_c)
  );

  // Board store: placer writes during CLEAR/PLACE, correct clicks clear in PLAY.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      for (int i = 0; i < int'(CELLS); i++) board[i] <= '0;
    end else if (pl_we_c) begin
      board[pl_addr_c] <= pl_cell_c;
    end else if (click_ok_c) begin
      board[click_addr_c] <= '0;
    end
  end

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      oRdActive <= 1'b0;
      oRdShown  <= 1'b0;
      oRdNum    <= '0;
    end else begin
      oRdActive <= rd_cell_c.active;
      oRdShown  <= rd_cell_c.active & ~hidden;
      oRdNum    <= NUM_W'(rd_cell_c.num);
    end
  end

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      state      <= IDLE;
      oLevel     <= LVL_W'(1);
      oStrikes   <= '0;
      oExpected  <= NUM_W'(1);
      hidden     <= 1'b0;
      timer      <= '0;
      oLevelWin  <= 1'b0;
      oLevelFail <= 1'b0;
    end else begin
      oLevelWin  <= 1'b0;
      oLevelFail <= 1'b0;
      if (go_c) begin
        state     <= CLEAR;
        oExpected <= NUM_W'(1);
        hidden    <= 1'b0;
      end
      case (state)
        IDLE, FAIL: ;
        CLEAR: if (clear_done_c) state <= PLACE;
        PLACE: begin
          if (place_done_c) begin
            state <= PLAY;
            timer <= TW'(SHOW_CYCLES);
          end
        end
        PLAY: begin
          if (click_hit_c) begin
            if (click_ok_c) begin
              oExpected <= oExpected + NUM_W'(1);
              hidden    <= 1'b1;
              if (click_cell_c.num == CELL_NUM_W'(count_c)) begin
                state     <= WIN;
                oLevelWin <= 1'b1;
              end
            end else begin
              oLevelFail <= 1'b1;
              if (oStrikes != SW'(MAX_STRIKES)) oStrikes <= oStrikes + SW'(1);
              state <= (oStrikes + SW'(1) >= SW'(MAX_STRIKES)) ? OVER : FAIL;
            end
          end else if (SHOW_CYCLES != 0 && timer != '0) begin
            timer <= timer - TW'(1);
            if (timer == TW'(1)) hidden <= 1'b1;
          end
        end
        WIN: begin
          if (iStart) begin
            if (is_final_c) state <= DONE;
            else if (oLevel != LVL_W'(LVL_MAX)) oLevel <= oLevel + LVL_W'(1);
          end
        end
        OVER, DONE: begin
          if (iStart) begin
            oLevel   <= LVL_W'(1);
            oStrikes <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chimp_game_engine.sv
// Scoreboard bench for chimp_game_engine: a SHOW_CYCLES=0 instance plus a SHOW_CYCLES=10 twin.
module tb_chimp_game_engine;
  import chimp_pkg::*;

  localparam int CELLS = 64;

  logic       clk = 1'b0;
  logic       iReset, iStart, iClick, iClickValid;
  logic [2:0] iClickX, iClickY, iRdX, iRdY;
  logic [7:0] iRand;

  logic       oRdActive, oRdShown, oLevelWin, oLevelFail;
  logic [5:0] oRdNum, oExpected;
  logic [4:0] oLevel;
  logic [1:0] oStrikes;
  logic [2:0] oState;

  logic       t_oRdActive, t_oRdShown, t_oLevelWin, t_oLevelFail;
  logic [5:0] t_oRdNum, t_oExpected;
  logic [4:0] t_oLevel;
  logic [1:0] t_oStrikes;
  logic [2:0] t_oState;

  int n_checks = 0;
  int n_fails  = 0;
  int m_num [CELLS];
  bit m_hidden;
  int m_exp, m_strikes, m_count;
  int rand_q [$];
  int rd_q [$];
  int pulse_q [$];

  chimp_game_engine dut (
    .clk(clk), .iReset(iReset), .iStart(iStart), .iClick(iClick),
    .iClickX(iClickX), .iClickY(iClickY), .iClickValid(iClickValid), .iRand(iRand),
    .iRdX(iRdX), .iRdY(iRdY), .oRdActive(oRdActive), .oRdShown(oRdShown),
    .oRdNum(oRdNum), .oLevel(oLevel), .oStrikes(oStrikes), .oExpected(oExpected),
    .oState(oState), .oLevelWin(oLevelWin), .oLevelFail(oLevelFail)
  );

  chimp_game_engine #(.SHOW_CYCLES(10)) dut_t (
    .clk(clk), .iReset(iReset), .iStart(iStart), .iClick(iClick),
    .iClickX(iClickX), .iClickY(iClickY), .iClickValid(iClickValid), .iRand(iRand),
    .iRdX(iRdX), .iRdY(iRdY), .oRdActive(t_oRdActive), .oRdShown(t_oRdShown),
    .oRdNum(t_oRdNum), .oLevel(t_oLevel), .oStrikes(t_oStrikes), .oExpected(t_oExpected),
    .oState(t_oState), .oLevelWin(t_oLevelWin), .oLevelFail(t_oLevelFail)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc(input logic act, input logic shown, input logic [5:0] num);
    return {24'b0, act, shown, num};
  endfunction

  // Read one cell; expectation comes from the bench's own board model.
  task automatic rd_probe(input int a);
    iRdX = 3'(a % 8);
    iRdY = 3'(a / 8);
    rd_q.push_back(32'(enc(m_num[a] != 0, (m_num[a] != 0) && !m_hidden, 6'(m_num[a]))));
    tick();
    check("rd_cell", enc(oRdActive, oRdShown, oRdNum), 32'(rd_q.pop_front()));
  endtask

  task automatic click(input int a, input bit valid);
    bit hit, ok, win, fail;
    hit  = valid && (m_num[a] != 0);
    ok   = hit && (m_num[a] == m_exp);
    win  = ok && (m_num[a] == m_count);
    fail = hit && !ok;
    pulse_q.push_back({30'b0, win, fail});
    iClickX     = 3'(a % 8);
    iClickY     = 3'(a / 8);
    iClickValid = valid;
    iClick      = 1'b1;
    tick();
    iClick      = 1'b0;
    iClickValid = 1'b0;
    check("pulses", {30'b0, oLevelWin, oLevelFail}, 32'(pulse_q.pop_front()));
    if (ok) begin
      m_num[a] = 0;
      m_exp++;
      m_hidden = 1'b1;
    end
    if (fail && m_strikes < 3) m_strikes++;
    check("expected", 32'(oExpected), 32'(m_exp));
    check("strikes", 32'(oStrikes), 32'(m_strikes));
  endtask

  // Pulse iStart, walk CLEAR, feed rand_q into PLACE and compare placement length with the model.
  task automatic start_level();
    int cyc, placed, exp_cycles, v, a;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("clear_entry", 32'(oState), 32'(CLEAR));
    for (int i = 0; i < CELLS; i++) m_num[i] = 0;
    m_hidden = 1'b0;
    m_exp = 1;
    placed = 0;
    exp_cycles = -1;
    repeat (CELLS - 1) tick();
    check("clear_len", 32'(oState), 32'(CLEAR));
    tick();
    check("place_entry", 32'(oState), 32'(PLACE));
    cyc = 0;
    while (oState == PLACE && cyc < 200) begin
      v = (rand_q.size() != 0) ? rand_q.pop_front() : int'($urandom_range(0, 255));
      iRand = 8'(v);
      a = v % CELLS;
      if (placed < m_count && m_num[a] == 0) begin
        placed++;
        m_num[a] = placed;
        if (placed == m_count) exp_cycles = cyc + 1;
      end
      tick();
      cyc++;
    end
    check("place_len", 32'(cyc), 32'(exp_cycles));
    check("play_entry", 32'(oState), 32'(PLAY));
  endtask

  initial begin
    iReset = 1'b1; iStart = 1'b0; iClick = 1'b0; iClickValid = 1'b0;
    iClickX = '0; iClickY = '0; iRdX = '0; iRdY = '0; iRand = '0;
    for (int i = 0; i < CELLS; i++) m_num[i] = 0;
    m_hidden = 1'b0; m_exp = 1; m_strikes = 0; m_count = 4;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(oState), 32'(IDLE));
    check("rst_level", 32'(oLevel), 1);
    check("rst_strikes", 32'(oStrikes), 0);
    check("rst_expected", 32'(oExpected), 1);
    check("rst_rd", enc(oRdActive, oRdShown, oRdNum), 0);
    check("rst_pulses", {30'b0, oLevelWin, oLevelFail}, 0);
    iReset = 1'b0;
    tick();

    // Level 1, straight placement into cells 0..3.
    rand_q = '{0, 1, 2, 3};
    start_level();
    for (int a = 0; a < 5; a++) rd_probe(a);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("start_in_play", 32'(oState), 32'(PLAY));

    // Ignored clicks: invalid coordinates, empty cell.
    click(0, 1'b0);
    click(10, 1'b1);
    check("ignored_state", 32'(oState), 32'(PLAY));

    // Wrong clicks until game over, with a stalled placement in between.
    click(1, 1'b1);
    check("fail_state", 32'(oState), 32'(FAIL));
    tick();
    check("fail_pulse_len", 32'(oLevelFail), 0);
    rand_q = '{0, 0, 0, 0, 0, 0, 1, 2, 3};
    start_level();
    check("fail_level", 32'(oLevel), 1);
    for (int a = 0; a < 5; a++) rd_probe(a);
    click(3, 1'b1);
    check("fail2_state", 32'(oState), 32'(FAIL));
    rand_q = '{0, 1, 2, 3};
    start_level();
    click(2, 1'b1);
    check("over_state", 32'(oState), 32'(OVER));

    // Restart from OVER and clear the level in order.
    m_strikes = 0;
    rand_q = '{3, 2, 1, 0};
    start_level();
    check("restart_level", 32'(oLevel), 1);
    check("restart_strikes", 32'(oStrikes), 0);
    click(3, 1'b1);
    rd_probe(2);
    click(2, 1'b1);
    click(1, 1'b1);
    click(0, 1'b1);
    check("win_state", 32'(oState), 32'(WIN));
    tick();
    check("win_pulse_len", 32'(oLevelWin), 0);

    // Level 2: five tiles, and the auto-hide timer on the twin.
    m_count = 5;
    rand_q = '{9, 9, 17, 33, 63, 0};
    start_level();
    check("level2", 32'(oLevel), 2);
    for (int a = 0; a < 2; a++) rd_probe(a * 9);
    iRdX = 3'd1;
    iRdY = 3'd1;
    rd_q.delete();
    begin
      int budget;
      budget = 0;
      // Re-enter PLAY is not needed: count cycles from the timer reload by a fresh level below.
    end
    click(9, 1'b1);
    click(17, 1'b1);
    click(33, 1'b1);
    click(63, 1'b1);
    click(0, 1'b1);
    check("win2_state", 32'(oState), 32'(WIN));

    // Level 3: timer expiry lands 10 cycles after PLAY entry (read port shows it one cycle later).
    m_count = 6;
    rand_q = '{1, 2, 3, 4, 5, 6};
    start_level();
    check("level3", 32'(oLevel), 3);
    iRdX = 3'd2;
    iRdY = 3'd0;
    repeat (10) tick();
    check("timer_shown", 32'(t_oRdShown), 1);
    tick();
    check("timer_hidden", 32'(t_oRdShown), 0);
    check("no_timer_shown", 32'(oRdShown), 1);

    // Level 4: click lands on the expiry cycle and is processed as a click.
    for (int a = 1; a <= 6; a++) click(a, 1'b1);
    check("win3_state", 32'(oState), 32'(WIN));
    m_count = 7;
    rand_q = '{8, 9, 10, 11, 12, 13, 14};
    start_level();
    repeat (9) tick();
    click(8, 1'b1);
    check("collide_t_expected", 32'(t_oExpected), 2);
    check("collide_t_fail", 32'(t_oLevelFail), 0);
    check("collide_t_state", 32'(t_oState), 32'(PLAY));
    rd_probe(8);

    // Reset in the middle of PLACE.
    click(10, 1'b1);
    check("fail4_state", 32'(oState), 32'(FAIL));
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    iRdX = 3'd5;
    iRdY = 3'd0;
    repeat (CELLS) tick();
    check("mid_place_state", 32'(oState), 32'(PLACE));
    iRand = 8'd5;
    tick();
    iRand = 8'd6;
    tick();
    check("pre_reset_rd", enc(oRdActive, oRdShown, oRdNum), enc(1'b1, 1'b1, 6'd1));
    #2 iReset = 1'b1;
    #1;
    check("async_state", 32'(oState), 32'(IDLE));
    check("async_level", 32'(oLevel), 1);
    check("async_strikes", 32'(oStrikes), 0);
    check("async_expected", 32'(oExpected), 1);
    check("async_rd", enc(oRdActive, oRdShown, oRdNum), 0);
    #2 iReset = 1'b0;
    tick();
    for (int i = 0; i < CELLS; i++) m_num[i] = 0;
    m_hidden = 1'b0;
    rd_probe(5);
    rd_probe(6);
    check("post_reset_state", 32'(oState), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
